alu_seq: RTL

- Parametrised, multi-cycle successor to the 32-bit ripple ALU.
- Keeps the logic, arithmetic and compare op set, and adds iterative unsigned multiply and divide.
- Wraps all ops in a valid/ready handshake so the block sits between operand fetch and writeback in the datapath.
- Single-cycle ops complete in one busy cycle; MUL/DIV run a WIDTH-step shift/add or shift/subtract engine.

---
 rtl/alu_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU behind a valid/ready handshake. It handles logic, add/sub and compare
// ops in one busy cycle, and unsigned multiply/divide through a WIDTH-step shift engine.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div0,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             to_iter;
  logic [WIDTH-1:0] add_r, sub_r, ex_res, ex_hi;
  logic             ex_ov, ex_d0, ex_ill;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE. out_valid stays high, with its data held, until out_ready.
  assign to_iter = (op == OP_MULU) || (op == OP_DIVU && b_in != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = to_iter ? ITER : EXEC;
      end
      EXEC: state_nx = DONE;
      ITER: if (cnt == LAST) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    add_r  = a_q + b_q;
    sub_r  = a_q - b_q;
    ex_res = '0;
    ex_hi  = '0;
    ex_ov  = 1'b0;
    ex_d0  = 1'b0;
    ex_ill = 1'b0;
    case (op_q)
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_ADD: begin
        ex_res = add_r;
        ex_ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res = sub_r;
        ex_ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: ex_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR: ex_res = ~(a_q | b_q);
      // Only a divide by zero reaches EXEC with DIVU.
      OP_DIVU: begin
        ex_res = '1;
        ex_hi  = a_q;
        ex_d0  = 1'b1;
      end
      default: ex_ill = 1'b1;
    endcase
  end

  // The iteration steps use lo_q as the multiplier/dividend shift register and hi_q as the accumulator/remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; hi_q <= '0; lo_q <= '0; op_q <= '0; cnt <= '0;
      result <= '0; result_hi <= '0;
      zero <= 1'b0; overflow <= 1'b0; div0 <= 1'b0; illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a_in; b_q <= b_in; op_q <= op;
          hi_q <= '0; lo_q <= a_in; cnt <= '0;
          result <= '0; result_hi <= '0;
          zero <= 1'b0; overflow <= 1'b0; div0 <= 1'b0; illegal <= 1'b0;
        end
        EXEC: begin
          result    <= ex_res;
          result_hi <= ex_hi;
          zero      <= (ex_res == '0);
          overflow  <= ex_ov;
          div0      <= ex_d0;
          illegal   <= ex_ill;
        end
        ITER: begin
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
            if (op_q == OP_MULU) begin
              hi_q <= mul_sum[WIDTH:1];
              lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
              hi_q <= div_diff[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_q <= div_shift[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            result    <= lo_q;
            result_hi <= hi_q;
            zero      <= (lo_q == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
